div_rem_seq: RTL

- Iterative sequential divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the counterpart of the Karatsuba/Booth multiply unit.
- It sits beside the multiplier in the execute stage and uses the same control interface: Enable/Done handshake, 12-bit {funct7[5:4],funct3,opcode}-style decode word, and tri-stated rd.
- Division is radix-2 non-restoring on magnitudes, one quotient bit per cycle, with sign fix-up at the end.

---
 rtl/div_rem_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/div_rem_seq.sv
// div_rem_seq -- iterative RV32M divider (DIV / DIVU / REM / REMU).
//
// Radix-2 non-restoring division on operand magnitudes. One quotient bit
// is produced per clock. Signs are fixed up in a final cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   Enable       start/hold request; held high until Done is seen
//   rs1, rs2     dividend, divisor (captured on the starting edge)
//   funct3       12-bit decode word {funct7[5:4], funct3, opcode}
//   rd           result; high-Z when funct3 is not a divide op
//   Done         registered result-valid flag
//   dbg_state_o  current FSM state, for observation only
//
// Handshake: Enable high in IDLE with a valid op starts a divide. Done
// rises with the result and stays high while Enable stays high. Dropping
// Enable before Done aborts the divide back to IDLE. Enable must be low
// for at least one cycle between operations.
//
// Optional macro DIV_EARLY_OUT_EN: finish in LOAD when |a| < |b| or when
// |b| == 1. Results are identical; only the latency changes.
module div_rem_seq #(
  parameter int XLEN      = 32,
  parameter int COUNT_BIT = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Enable,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [11:0]     funct3,
  output logic [XLEN-1:0] rd,
  output logic            Done,
  output logic [2:0]      dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t               state_q, state_d;
  logic [XLEN-1:0]      a_q, a_d;      // dividend, shifted into the quotient
  logic [XLEN-1:0]      b_q, b_d;      // divisor (magnitude after LOAD)
  logic [XLEN:0]        p_q, p_d;      // signed partial remainder
  logic [COUNT_BIT-1:0] cnt_q, cnt_d;
  logic                 is_rem_q, is_rem_d;
  logic                 is_uns_q, is_uns_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 forced_q, forced_d;   // special result, skip fix-up
  logic [XLEN-1:0]      res_q, res_d;
  logic                 done_q;

  // funct3[9] is always 1 for divide ops; [8] selects REM, [7] unsigned.
  logic is_oper;
  assign is_oper = (funct3[11:9] == 3'b011) && (funct3[6:0] == 7'b0110011);

  assign rd          = is_oper ? res_q : {XLEN{1'bz}};
  assign Done        = done_q;
  assign dbg_state_o = state_q;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   p_shift, p_step;
  logic [XLEN-1:0] r_mag, q_out, r_out;

  always_comb begin
    a_neg   = ~is_uns_q & a_q[XLEN-1];
    b_neg   = ~is_uns_q & b_q[XLEN-1];
    a_mag   = a_neg ? (~a_q + 1'b1) : a_q;
    b_mag   = b_neg ? (~b_q + 1'b1) : b_q;
    // Non-restoring step: subtract when the remainder is non-negative,
    // add it back otherwise. Arithmetic wraps at XLEN+1 bits but the true
    // result always lies in [-|b|, |b|), so it is exact.
    p_shift = {p_q[XLEN-1:0], a_q[XLEN-1]};
    p_step  = p_q[XLEN] ? (p_shift + {1'b0, b_q}) : (p_shift - {1'b0, b_q});
    // Final restore; the result lies in [0, |b|) so XLEN bits suffice.
    r_mag   = p_q[XLEN] ? (p_q[XLEN-1:0] + b_q) : p_q[XLEN-1:0];
    q_out   = forced_q ? a_q : (qneg_q ? (~a_q + 1'b1) : a_q);
    r_out   = forced_q ? p_q[XLEN-1:0] : (rneg_q ? (~r_mag + 1'b1) : r_mag);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    is_rem_d = is_rem_q;
    is_uns_d = is_uns_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    forced_d = forced_q;
    res_d    = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (Enable && is_oper) begin
          a_d      = rs1;
          b_d      = rs2;
          is_rem_d = funct3[8];
          is_uns_d = funct3[7];
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!Enable) begin
          state_d = S_IDLE;
        end else begin
          qneg_d   = a_neg ^ b_neg;
          rneg_d   = a_neg;
          p_d      = '0;
          cnt_d    = '0;
          forced_d = 1'b0;
          a_d      = a_mag;
          b_d      = b_mag;
          state_d  = S_CALC;
          if (b_q == '0) begin
            a_d      = '1;
            p_d      = {1'b0, a_q};
            forced_d = 1'b1;
            state_d  = S_FIX;
          end else if (!is_uns_q && (a_q == INT_MIN) && (b_q == '1)) begin
            a_d      = INT_MIN;
            forced_d = 1'b1;
            state_d  = S_FIX;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (b_mag == {{(XLEN-1){1'b0}}, 1'b1}) begin
            // Quotient is |a|; sign fix-up in FIX handles the rest.
            state_d = S_FIX;
          end else if (a_mag < b_mag) begin
            a_d      = '0;
            p_d      = {1'b0, a_q};
            forced_d = 1'b1;
            state_d  = S_FIX;
          end
`endif
        end
      end
      S_CALC: begin
        if (!Enable) begin
          state_d = S_IDLE;
        end else begin
          p_d   = p_step;
          a_d   = {a_q[XLEN-2:0], ~p_step[XLEN]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == COUNT_BIT'(XLEN-1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (!Enable) begin
          state_d = S_IDLE;
        end else begin
          res_d   = is_rem_q ? r_out : q_out;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!Enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      is_uns_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      forced_q <= 1'b0;
      res_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      is_rem_q <= is_rem_d;
      is_uns_q <= is_uns_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      forced_q <= forced_d;
      res_q    <= res_d;
      done_q   <= (state_d == S_DONE);
    end
  end

endmodule
